apb_xfer_ctrl: RTL and testbench

Sequencer for the bridge's APB side. It buffers transfer requests from the AHB-side logic in a small FIFO and decodes each address to one of three APB slave selects. It then drives the APB SETUP/ACCESS protocol (Pselx, Penable, Pwrite, Paddr, Pwdata) into the APB interface block and returns captured read data or a decode error as a one-cycle response.

---
 rtl/apb_xfer_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_apb_xfer_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_xfer_ctrl.sv
// APB-side sequencer: queues requests, decodes a slave select and runs SETUP/ACCESS, 4+WAIT_CYCLES accept-to-response (2 on decode miss).
// Backpressure: req_ready drops while the request FIFO is full or in reset; the response pulse is never stalled.
module apb_xfer_ctrl #(
    parameter int WAIT_CYCLES = 1,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [2:0]  Pselx,
    output logic        Penable,
    output logic        Pwrite,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    input  logic [31:0] Prdata,
    output logic [15:0] xfer_count,
    output logic [7:0]  err_count
);

    localparam int              AW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C = FIFO_DEPTH[CW-1:0];
    localparam logic [2:0]      WAIT_C  = WAIT_CYCLES[2:0];

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    req_t          r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_sel;
    logic [2:0]    r_wait;
    logic          r_write;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_err_pend;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [31:0]   r_rsp_rdata;
    logic [15:0]   r_xfer_count;
    logic [7:0]    r_err_count;

    req_t          w_head;
    logic [2:0]    w_head_sel;
    logic          w_head_hit;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic          w_done;
    logic          w_err_rsp;
    logic          w_pend_set;

    function automatic logic [2:0] f_decode(input logic [5:0] region);
        case (region)
            6'b100000: f_decode = 3'b001;
            6'b100001: f_decode = 3'b010;
            6'b100010: f_decode = 3'b100;
            default:   f_decode = 3'b000;
        endcase
    endfunction

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == DEPTH_C);
    assign req_ready  = !w_full && !Hreset;
    assign w_push     = req_valid && req_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_sel = f_decode(w_head.addr[31:26]);
    assign w_head_hit = |w_head_sel;

    always_ff @(posedge Hclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_write, req_addr, req_wdata};
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A miss popped at the end of ACCESS collides with that transfer's own
    // response, so its error response is parked and emitted from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_err_rsp   = 1'b0;
        w_pend_set  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_err_pend) begin
                    w_err_rsp = 1'b1;
                end else if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_hit) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_err_rsp = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (r_wait == 3'd0) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_head_hit) begin
                            w_load      = 1'b1;
                            w_state_nxt = ST_SETUP;
                        end else begin
                            w_pend_set = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_sel        <= '0;
            r_wait       <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_err_pend   <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
            r_xfer_count <= '0;
            r_err_count  <= '0;
        end else begin
            if (w_load) begin
                r_sel   <= w_head_sel;
                r_write <= w_head.write;
                r_addr  <= w_head.addr;
                r_wdata <= w_head.wdata;
            end
            if (r_state == ST_SETUP) begin
                r_wait <= WAIT_C;
            end else if (r_state == ST_ACCESS && r_wait != 3'd0) begin
                r_wait <= r_wait - 3'd1;
            end
            if (w_pend_set) begin
                r_err_pend <= 1'b1;
            end else if (w_err_rsp) begin
                r_err_pend <= 1'b0;
            end
            r_rsp_valid <= w_done || w_err_rsp;
            if (w_done) begin
                r_rsp_err    <= 1'b0;
                r_rsp_rdata  <= r_write ? 32'h0 : Prdata;
                r_xfer_count <= r_xfer_count + 16'd1;
            end else if (w_err_rsp) begin
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= 32'h0;
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign Pselx      = (r_state == ST_IDLE) ? 3'b000 : r_sel;
    assign Penable    = (r_state == ST_ACCESS);
    assign Pwrite     = r_write;
    assign Paddr      = r_addr;
    assign Pwdata     = r_wdata;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_err    = r_rsp_err;
    assign rsp_rdata  = r_rsp_rdata;
    assign xfer_count = r_xfer_count;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_apb_xfer_ctrl.sv
// Bench for apb_xfer_ctrl: vector table plus multi-cycle sequences; responses checked in order against a queue.
// The APB slave model returns Paddr ^ RD_KEY during ACCESS and garbage otherwise.
module tb_apb_xfer_ctrl;

    localparam int          W      = 1;
    localparam int          D      = 2;
    localparam logic [31:0] RD_KEY = 32'h8000_00B5;

    logic        Hclk;
    logic        Hreset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic [15:0] xfer_count;
    logic [7:0]  err_count;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  sel;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[7];

    int n_checks = 0;
    int n_errors = 0;
    int n_hit    = 0;
    int n_miss   = 0;
    int n_stall  = 0;

    apb_xfer_ctrl #(.WAIT_CYCLES(W), .FIFO_DEPTH(D)) dut (
        .Hclk       (Hclk),
        .Hreset     (Hreset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .Pselx      (Pselx),
        .Penable    (Penable),
        .Pwrite     (Pwrite),
        .Paddr      (Paddr),
        .Pwdata     (Pwdata),
        .Prdata     (Prdata),
        .xfer_count (xfer_count),
        .err_count  (err_count)
    );

    assign Prdata = Penable ? (Paddr ^ RD_KEY) : 32'hDEAD_BEEF;

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    function automatic logic addr_hit(input logic [31:0] a);
        logic [5:0] r;
        r = a[31:26];
        return (r >= 6'd32) && (r <= 6'd34);
    endfunction

    function automatic logic [7:0] err_model();
        return (n_miss > 255) ? 8'hFF : n_miss[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
        end
    endtask

    // One clock: record acceptance before the edge, then check any response at the next negedge.
    task automatic step(output logic acc);
        exp_t e;
        acc = 1'b0;
        #1;
        if (Hreset) begin
            exp_q.delete();
            n_hit  = 0;
            n_miss = 0;
        end else if (req_valid) begin
            if (req_ready) begin
                acc     = 1'b1;
                e.err   = !addr_hit(req_addr);
                e.rdata = (e.err || req_write) ? 32'h0 : (req_addr ^ RD_KEY);
                exp_q.push_back(e);
                if (e.err) n_miss++;
                else       n_hit++;
            end else begin
                n_stall++;
            end
        end
        @(negedge Hclk);
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 with no outstanding request, expected 0");
            end else begin
                e = exp_q.pop_front();
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    endtask

    task automatic tick();
        logic a;
        step(a);
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic acc;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        acc       = 1'b0;
        for (int i = 0; i < 64 && !acc; i++) step(acc);
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: addr 0x%08h not accepted in 64 cycles, expected acceptance", a);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
        tick();
        tick();
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [31:0] last_addr;
        int          bb_sel [8];
        int          bb_pen [8];
        int          bb_rsp [8];
        int          n_act;

        Hreset    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        last_addr = '0;
        vecs = '{
            '{1'b0, 32'h8000_0010, 32'h0000_0000, 3'b001},
            '{1'b1, 32'h8400_0000, 32'hA5A5_0001, 3'b010},
            '{1'b0, 32'h8800_0ABC, 32'h0000_0000, 3'b100},
            '{1'b0, 32'h1234_0000, 32'h0000_0000, 3'b000},
            '{1'b1, 32'h7C00_0000, 32'h5555_AAAA, 3'b000},
            '{1'b0, 32'h8C00_0000, 32'h0000_0000, 3'b000},
            '{1'b1, 32'h83FF_FFFC, 32'h0F0F_0F0F, 3'b001}
        };
        bb_sel = '{0, 2, 2, 2, 4, 4, 4, 0};
        bb_pen = '{0, 0, 1, 1, 0, 1, 1, 0};
        bb_rsp = '{0, 0, 0, 0, 1, 0, 0, 1};

        // Reset values
        tick();
        chk("rst_ready_c1", 32'(req_ready), 32'd0);
        tick();
        chk("rst_ready_c2", 32'(req_ready), 32'd0);
        chk("rst_ctrl", 32'({rsp_valid, rsp_err, Pselx, Penable, Pwrite}), 32'd0);
        chk("rst_paddr", Paddr, 32'd0);
        chk("rst_pwdata", Pwdata, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_counts", {8'h0, xfer_count, err_count}, 32'd0);
        Hreset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Isolated single requests: hits and decode misses
        foreach (vecs[v]) begin
            int          lat;
            logic        hit;
            logic [2:0]  e_sel;
            logic        e_pen;
            hit = (vecs[v].sel != 3'b000);
            lat = hit ? (4 + W) : 2;
            req_valid = 1'b1;
            req_write = vecs[v].wr;
            req_addr  = vecs[v].addr;
            req_wdata = vecs[v].wdata;
            step(acc);
            chk($sformatf("v%0d_accept", v), 32'(acc), 32'd1);
            req_valid = 1'b0;
            for (int c = 1; c <= lat; c++) begin
                if (c > 1) tick();
                e_sel = (hit && c >= 2 && c < lat) ? vecs[v].sel : 3'b000;
                e_pen = hit && c >= 3 && c < lat;
                chk($sformatf("v%0d_c%0d_pselx", v, c), 32'(Pselx), 32'(e_sel));
                chk($sformatf("v%0d_c%0d_penable", v, c), 32'(Penable), 32'(e_pen));
                chk($sformatf("v%0d_c%0d_rsp_valid", v, c), 32'(rsp_valid), 32'(c == lat));
                if (hit && c == 2) begin
                    chk($sformatf("v%0d_paddr", v), Paddr, vecs[v].addr);
                    chk($sformatf("v%0d_pwrite", v), 32'(Pwrite), 32'(vecs[v].wr));
                    chk($sformatf("v%0d_pwdata", v), Pwdata, vecs[v].wdata);
                end
            end
            if (hit) last_addr = vecs[v].addr;
            else     chk($sformatf("v%0d_paddr_hold", v), Paddr, last_addr);
            chk($sformatf("v%0d_xfer_count", v), 32'(xfer_count), 32'(n_hit[15:0]));
            chk($sformatf("v%0d_err_count", v), 32'(err_count), 32'(err_model()));
        end

        // Back-to-back writes: second SETUP coincides with first response
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h8400_0000;
        req_wdata = 32'h1111_2222;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                req_addr  = 32'h8800_0004;
                req_wdata = 32'h3333_4444;
            end
            if (c == 2) req_valid = 1'b0;
            chk($sformatf("bb_c%0d_pselx", c), 32'(Pselx), 32'(bb_sel[c-1]));
            chk($sformatf("bb_c%0d_penable", c), 32'(Penable), 32'(bb_pen[c-1]));
            chk($sformatf("bb_c%0d_rsp_valid", c), 32'(rsp_valid), 32'(bb_rsp[c-1]));
            if (c == 5) begin
                chk("bb_paddr2", Paddr, 32'h8800_0004);
                chk("bb_pwdata2", Pwdata, 32'h3333_4444);
            end
        end
        chk("bb_xfer_count", 32'(xfer_count), 32'(n_hit[15:0]));

        // Fill and backpressure
        n_stall = 0;
        send(1'b0, 32'h8000_0100, 32'h0);
        send(1'b1, 32'h8400_0200, 32'hCAFE_0001);
        send(1'b0, 32'h8800_0300, 32'h0);
        send(1'b1, 32'h8000_0400, 32'hCAFE_0002);
        req_valid = 1'b0;
        chk("fill_stalled", 32'(n_stall > 0), 32'd1);
        drain("fill_drain");
        chk("fill_xfer_count", 32'(xfer_count), 32'(n_hit[15:0]));

        // Misses queued behind an active transfer
        send(1'b0, 32'h8000_0500, 32'h0);
        send(1'b0, 32'h0000_0000, 32'h0);
        send(1'b1, 32'hFC00_0000, 32'h7777_7777);
        send(1'b1, 32'h8800_0600, 32'h9999_0000);
        req_valid = 1'b0;
        drain("mix_drain");
        chk("mix_xfer_count", 32'(xfer_count), 32'(n_hit[15:0]));
        chk("mix_err_count", 32'(err_count), 32'(err_model()));

        // err_count saturation
        for (int i = 0; i < 260; i++) send(1'(i & 1), 32'h4000_0000 | 32'(i), 32'(i));
        req_valid = 1'b0;
        drain("sat_drain");
        chk("sat_err_count", 32'(err_count), 32'h0000_00FF);
        chk("sat_err_model", 32'(err_count), 32'(err_model()));
        chk("sat_xfer_count", 32'(xfer_count), 32'(n_hit[15:0]));

        // Reset in the first ACCESS cycle with a second request queued
        send(1'b0, 32'h8000_0020, 32'h0);
        req_addr = 32'h8400_0024;
        tick();
        req_valid = 1'b0;
        tick();
        chk("abort_penable_before", 32'(Penable), 32'd1);
        Hreset = 1'b1;
        tick();
        chk("abort_pselx", 32'(Pselx), 32'd0);
        chk("abort_penable", 32'(Penable), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_counts", {8'h0, xfer_count, err_count}, 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        Hreset = 1'b0;
        n_act  = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (Pselx != 3'b000 || rsp_valid) n_act++;
        end
        chk("abort_quiet", 32'(n_act), 32'd0);
        chk("abort_ready_after", 32'(req_ready), 32'd1);

        send(1'b0, 32'h8000_0010, 32'h0);
        req_valid = 1'b0;
        drain("post_rst_drain");
        chk("post_rst_xfer_count", 32'(xfer_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
